// File: rtl/sram_byte_sequencer_pkg.sv
// Shared types and constants for the serial SRAM byte sequencer.
package sram_byte_sequencer_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADR2,
    S_ADR1,
    S_ADR0,
    S_WAIT_WDATA,
    S_DATA,
    S_INSTR,
    S_GUARD,
    S_POLL,
    S_RDATA,
    S_NEXT,
    S_ABORT
  } state_t;

  localparam logic [7:0] INSTR_READ  = 8'h03;
  localparam logic [7:0] INSTR_WRITE = 8'h02;

  localparam int CSR_WR_BUSY    = 1;
  localparam int CSR_DATA_AVAIL = 2;
  localparam int CSR_CS_ACTIVE  = 3;

  // The SRAM decodes only the low 17 address bits; the upper bits ride along.
  localparam int SRAM_ADDR_BITS = 17;

  // Next byte address: low SRAM_ADDR_BITS wrap, upper bits are held.
  function automatic logic [23:0] next_addr(input logic [23:0] a);
    next_addr = {a[23:SRAM_ADDR_BITS], a[SRAM_ADDR_BITS-1:0] + 1'b1};
  endfunction

endpackage

// File: rtl/sram_byte_sequencer_if.sv
// Wishbone link between the byte sequencer (master) and the SRAM register wrapper (slave).
interface sram_byte_sequencer_if;
  logic       stb_o;
  logic       we_o;
  logic [7:0] adr_wr_o;
  logic [7:0] adr_rd_o;
  logic [7:0] dat_o;
  logic [7:0] dat_i;
  logic       ack_i;

  modport master (
    output stb_o, we_o, adr_wr_o, adr_rd_o, dat_o,
    input  dat_i, ack_i
  );

  modport slave (
    input  stb_o, we_o, adr_wr_o, adr_rd_o, dat_o,
    output dat_i, ack_i
  );
endinterface

// File: rtl/sram_byte_sequencer.sv
// Wishbone master that turns client burst commands into the byte-mode SRAM
// wrapper's register sequence: address bytes, data, instruction, CSR poll, readback.
// Optional: define SRAM_BYTE_SEQUENCER_TIMEOUT_EN to abort a stuck poll after
// POLL_TIMEOUT cycles (wrapper reset via CSR, sticky err).
module sram_byte_sequencer
  import sram_byte_sequencer_pkg::*;
#(
  parameter logic [7:0]  REG_ADDR_INSTRUCTION = 8'h00,
  parameter logic [7:0]  REG_ADDR_DATA        = 8'h01,
  parameter logic [7:0]  REG_ADDR_ADDRESS2    = 8'h02,
  parameter logic [7:0]  REG_ADDR_ADDRESS1    = 8'h03,
  parameter logic [7:0]  REG_ADDR_ADDRESS0    = 8'h04,
  parameter logic [7:0]  REG_ADDR_CSR         = 8'h05,
  parameter int unsigned GUARD_CYCLES         = 4
`ifdef SRAM_BYTE_SEQUENCER_TIMEOUT_EN
  , parameter int unsigned POLL_TIMEOUT       = 4096
`endif
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [23:0]                  cmd_addr,
  input  logic [7:0]                   cmd_len_m1,
  input  logic                         wdata_valid,
  output logic                         wdata_ready,
  input  logic [7:0]                   wdata,
  output logic                         rdata_valid,
  output logic [7:0]                   rdata,
  output logic                         done,
  output logic                         err,
  sram_byte_sequencer_if.master        wb
);

  state_t      state;
  logic [23:0] cur_addr;
  logic [7:0]  remain;
  logic        is_wr;
  logic [7:0]  guard_cnt;
  logic [23:0] nxt_addr;
  logic [7:0]  csr;
  logic        poll_ok;

  assign nxt_addr = next_addr(cur_addr);

  // While stb_o is low the read address sits on the CSR, so dat_i is the live status.
  assign csr     = wb.dat_i;
  assign poll_ok = !csr[CSR_CS_ACTIVE] &&
                   (is_wr ? !csr[CSR_WR_BUSY] : csr[CSR_DATA_AVAIL]);

`ifdef SRAM_BYTE_SEQUENCER_TIMEOUT_EN
  logic [15:0] poll_cnt;
`else
  assign err = 1'b0;
`endif

  // Burst FSM; every output is a register set up one state ahead of its use.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cur_addr    <= '0;
      remain      <= '0;
      is_wr       <= 1'b0;
      guard_cnt   <= '0;
      cmd_ready   <= 1'b0;
      wdata_ready <= 1'b0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
      done        <= 1'b0;
      wb.stb_o    <= 1'b0;
      wb.we_o     <= 1'b0;
      wb.adr_wr_o <= '0;
      wb.adr_rd_o <= REG_ADDR_CSR;
      wb.dat_o    <= '0;
`ifdef SRAM_BYTE_SEQUENCER_TIMEOUT_EN
      poll_cnt    <= '0;
      err         <= 1'b0;
`endif
    end else begin
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready   <= 1'b0;
            cur_addr    <= cmd_addr;
            remain      <= cmd_len_m1;
            is_wr       <= cmd_write;
            wb.stb_o    <= 1'b1;
            wb.we_o     <= 1'b1;
            wb.adr_wr_o <= REG_ADDR_ADDRESS2;
            wb.dat_o    <= cmd_addr[23:16];
            state       <= S_ADR2;
`ifdef SRAM_BYTE_SEQUENCER_TIMEOUT_EN
            err         <= 1'b0;
`endif
          end
        end
        S_ADR2: if (wb.ack_i) begin
          wb.adr_wr_o <= REG_ADDR_ADDRESS1;
          wb.dat_o    <= cur_addr[15:8];
          state       <= S_ADR1;
        end
        S_ADR1: if (wb.ack_i) begin
          wb.adr_wr_o <= REG_ADDR_ADDRESS0;
          wb.dat_o    <= cur_addr[7:0];
          state       <= S_ADR0;
        end
        S_ADR0: if (wb.ack_i) begin
          if (is_wr) begin
            wb.stb_o    <= 1'b0;
            wb.we_o     <= 1'b0;
            wb.adr_wr_o <= '0;
            wb.dat_o    <= '0;
            wdata_ready <= 1'b1;
            state       <= S_WAIT_WDATA;
          end else begin
            wb.adr_wr_o <= REG_ADDR_INSTRUCTION;
            wb.dat_o    <= INSTR_READ;
            state       <= S_INSTR;
          end
        end
        S_WAIT_WDATA: if (wdata_valid) begin
          wdata_ready <= 1'b0;
          wb.stb_o    <= 1'b1;
          wb.we_o     <= 1'b1;
          wb.adr_wr_o <= REG_ADDR_DATA;
          wb.dat_o    <= wdata;
          state       <= S_DATA;
        end
        S_DATA: if (wb.ack_i) begin
          wb.adr_wr_o <= REG_ADDR_INSTRUCTION;
          wb.dat_o    <= INSTR_WRITE;
          state       <= S_INSTR;
        end
        S_INSTR: if (wb.ack_i) begin
          wb.stb_o    <= 1'b0;
          wb.we_o     <= 1'b0;
          wb.adr_wr_o <= '0;
          wb.dat_o    <= '0;
          guard_cnt   <= '0;
          state       <= S_GUARD;
        end
        // Give the wrapper time to raise its busy flags before the first poll.
        S_GUARD: begin
          if (guard_cnt == 8'(GUARD_CYCLES - 1)) begin
            state    <= S_POLL;
`ifdef SRAM_BYTE_SEQUENCER_TIMEOUT_EN
            poll_cnt <= '0;
`endif
          end else begin
            guard_cnt <= guard_cnt + 8'd1;
          end
        end
        S_POLL: begin
`ifdef SRAM_BYTE_SEQUENCER_TIMEOUT_EN
          poll_cnt <= poll_cnt + 16'd1;
`endif
          if (poll_ok) begin
            if (is_wr) begin
              state <= S_NEXT;
            end else begin
              wb.stb_o    <= 1'b1;
              wb.we_o     <= 1'b0;
              wb.adr_rd_o <= REG_ADDR_DATA;
              state       <= S_RDATA;
            end
          end
`ifdef SRAM_BYTE_SEQUENCER_TIMEOUT_EN
          else if (poll_cnt == 16'(POLL_TIMEOUT - 1)) begin
            wb.stb_o    <= 1'b1;
            wb.we_o     <= 1'b1;
            wb.adr_wr_o <= REG_ADDR_CSR;
            wb.dat_o    <= 8'h01;
            state       <= S_ABORT;
          end
`endif
        end
        S_RDATA: if (wb.ack_i) begin
          rdata       <= wb.dat_i;
          rdata_valid <= 1'b1;
          wb.stb_o    <= 1'b0;
          wb.adr_rd_o <= REG_ADDR_CSR;
          state       <= S_NEXT;
        end
        S_NEXT: begin
          if (remain == 8'd0) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            remain      <= remain - 8'd1;
            cur_addr    <= nxt_addr;
            wb.stb_o    <= 1'b1;
            wb.we_o     <= 1'b1;
            wb.adr_wr_o <= REG_ADDR_ADDRESS2;
            wb.dat_o    <= nxt_addr[23:16];
            state       <= S_ADR2;
          end
        end
`ifdef SRAM_BYTE_SEQUENCER_TIMEOUT_EN
        // Wrapper sync-reset write after a poll timeout; burst ends with err.
        S_ABORT: if (wb.ack_i) begin
          wb.stb_o    <= 1'b0;
          wb.we_o     <= 1'b0;
          wb.adr_wr_o <= '0;
          wb.dat_o    <= '0;
          err         <= 1'b1;
          done        <= 1'b1;
          state       <= S_IDLE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_byte_sequencer.sv
// Self-checking bench: behavioural SRAM wrapper model on the Wishbone side,
// spec-level expected memory image, randomized bursts.
module tb_sram_byte_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic        cmd_ready;
  logic [23:0] cmd_addr = '0;
  logic [7:0]  cmd_len_m1 = '0;
  logic        wdata_valid = 1'b0, wdata_ready;
  logic [7:0]  wdata = '0;
  logic        rdata_valid, done, err;
  logic [7:0]  rdata;

  always #5 clk = ~clk;

  sram_byte_sequencer_if wb();

  sram_byte_sequencer #(
    .GUARD_CYCLES(4)
`ifdef SRAM_BYTE_SEQUENCER_TIMEOUT_EN
    , .POLL_TIMEOUT(16)
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len_m1(cmd_len_m1),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata), .done(done), .err(err),
    .wb(wb)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- wrapper + SRAM model ----------------
  logic [7:0]  r_a2 = '0, r_a1 = '0, r_a0 = '0, r_dat = '0;
  logic        busy = 1'b0, avail = 1'b0, pend_wr = 1'b0, ack_en = 1'b1;
  int          spi_cnt = 0;
  bit          stall_spi = 1'b0, model_clr = 1'b0, ack_all = 1'b0;
  logic [7:0]  mem [logic [23:0]];
  int          cyc = 0, done_cnt = 0, wcnt = 0, csr_rst_cnt = 0;
  logic [15:0] wb_log [$];
  int          log_cyc [$];
  logic [7:0]  rq [$];

  assign wb.ack_i = wb.stb_o & ack_en;

  always_comb begin
    wb.dat_i = 8'h00;
    case (wb.adr_rd_o)
      8'h01: wb.dat_i = r_dat;
      8'h02: wb.dat_i = r_a2;
      8'h03: wb.dat_i = r_a1;
      8'h04: wb.dat_i = r_a0;
      8'h05: wb.dat_i = {4'h0, busy, avail, busy & pend_wr, 1'b0};
      default: ;
    endcase
  end

  function automatic logic [7:0] mem_rd(input logic [23:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    ack_en <= ack_all || ($urandom_range(3) != 0);
    if (done) done_cnt <= done_cnt + 1;
    if (rdata_valid) rq.push_back(rdata);
    if (wdata_valid && wdata_ready) wcnt <= wcnt + 1;
    if (model_clr) begin
      busy  <= 1'b0;
      avail <= 1'b0;
    end else if (wb.stb_o && wb.ack_i) begin
      if (wb.we_o) begin
        wb_log.push_back({wb.adr_wr_o, wb.dat_o});
        log_cyc.push_back(cyc);
        case (wb.adr_wr_o)
          8'h01: r_dat <= wb.dat_o;
          8'h02: r_a2  <= wb.dat_o;
          8'h03: r_a1  <= wb.dat_o;
          8'h04: r_a0  <= wb.dat_o;
          8'h00: begin
            busy    <= 1'b1;
            pend_wr <= (wb.dat_o == 8'h02);
            spi_cnt <= $urandom_range(12, 3);
            if (wb.dat_o == 8'h03) avail <= 1'b0;
          end
          8'h05: if (wb.dat_o[0]) begin
            busy        <= 1'b0;
            avail       <= 1'b0;
            csr_rst_cnt <= csr_rst_cnt + 1;
          end
          default: ;
        endcase
      end else if (wb.adr_rd_o == 8'h01) begin
        avail <= 1'b0;
      end
    end else if (busy && !stall_spi) begin
      if (spi_cnt > 0) spi_cnt <= spi_cnt - 1;
      else begin
        busy <= 1'b0;
        if (pend_wr) mem[{r_a2, r_a1, r_a0}] = r_dat;
        else begin
          r_dat <= mem_rd({r_a2, r_a1, r_a0});
          avail <= 1'b1;
        end
      end
    end
  end

  // ---------------- spec-level reference ----------------
  logic [7:0] exp_mem [logic [23:0]];
  logic [7:0] wq [$];

  function automatic logic [23:0] exp_addr(input logic [23:0] base, input int i);
    logic [23:0] lo;
    lo = base + 24'(i);
    return (base & 24'hFE0000) | (lo & 24'h01FFFF);
  endfunction

  function automatic logic [7:0] exp_rd(input logic [23:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : 8'h00;
  endfunction

  // Stimulus driver: issues one command, feeds wq bytes, waits for done.
  task automatic run_burst(input bit wr, input logic [23:0] a, input int n, output bit ok);
    int k, w0, d0;
    ok = 1'b0;
    k = 0;
    while (!cmd_ready && k < 200) begin @(posedge clk); #1; k++; end
    if (!cmd_ready) return;
    w0 = wcnt; d0 = done_cnt;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len_m1 = 8'(n - 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (k = 0; k < 20000 && done_cnt == d0; k++) begin
      wdata_valid = wr && ((wcnt - w0) < n);
      if (wdata_valid) wdata = wq[wcnt - w0];
      @(posedge clk); #1;
    end
    wdata_valid = 1'b0;
    ok = (done_cnt != d0);
    if (wr && ok) for (int i = 0; i < n; i++) exp_mem[exp_addr(a, i)] = wq[i];
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [38:0] obs;
    repeat (3) @(posedge clk);
    #1;
    obs = {cmd_ready, wdata_ready, rdata_valid, done, err, wb.stb_o, wb.we_o,
           wb.adr_wr_o, wb.adr_rd_o, wb.dat_o, rdata};
    n_tests++;
    if (obs !== {7'b0, 8'h00, 8'h05, 8'h00, 8'h00}) begin
      n_fail++; $display("FAIL reset_values: got %h expected %h", obs, {7'b0, 32'h00050000});
    end
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_write_one();
    int l0, d0; bit ok;
    logic [15:0] exp_seq [5];
    exp_seq = '{16'h0200, 16'h0300, 16'h0410, 16'h01A5, 16'h0002};
    l0 = wb_log.size(); d0 = done_cnt;
    wq = '{8'hA5};
    run_burst(1'b1, 24'h000010, 1, ok);
    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    if (!ok || wb_log.size() - l0 != 5) begin
      n_fail++; $display("FAIL write1_count: got %0d writes (done %0b) expected 5", wb_log.size() - l0, ok);
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (wb_log[l0 + i] !== exp_seq[i]) begin
          n_fail++; $display("FAIL write1_seq%0d: got %h expected %h", i, wb_log[l0 + i], exp_seq[i]);
        end
      end
    end
    n_tests++;
    if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL write1_done: got %0d pulses expected 1", done_cnt - d0); end
    n_tests++;
    if (mem_rd(24'h000010) !== 8'hA5) begin n_fail++; $display("FAIL write1_mem: got %h expected a5", mem_rd(24'h000010)); end
  endtask

  task automatic test_read_four();
    int r0; bit ok;
    wq = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_burst(1'b1, 24'h000010, 4, ok);
    r0 = rq.size();
    run_burst(1'b0, 24'h000010, 4, ok);
    n_tests++;
    if (!ok || rq.size() - r0 != 4) begin
      n_fail++; $display("FAIL read4_count: got %0d bytes (done %0b) expected 4", rq.size() - r0, ok);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (rq[r0 + i] !== wq[i]) begin
          n_fail++; $display("FAIL read4_byte%0d: got %h expected %h", i, rq[r0 + i], wq[i]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [23:0] bases [2];
    logic [23:0] a1;
    int l0; bit ok;
    bases = '{24'h01FFFF, 24'h5FFFFF};
    foreach (bases[b]) begin
      wq = '{8'($urandom), 8'($urandom)};
      l0 = wb_log.size();
      run_burst(1'b1, bases[b], 2, ok);
      a1 = exp_addr(bases[b], 1);
      n_tests++;
      if (!ok || mem_rd(a1) !== wq[1] || mem_rd(bases[b]) !== wq[0]) begin
        n_fail++; $display("FAIL wrap_mem_%h: got %h/%h expected %h/%h", bases[b],
                           mem_rd(bases[b]), mem_rd(a1), wq[0], wq[1]);
      end
      n_tests++;
      if (wb_log.size() - l0 < 6 || wb_log[l0 + 5] !== {8'h02, a1[23:16]}) begin
        n_fail++; $display("FAIL wrap_adr2_%h: got %h expected %h", bases[b],
                           (wb_log.size() - l0 < 6) ? 16'hxxxx : wb_log[l0 + 5], {8'h02, a1[23:16]});
      end
    end
  endtask

  task automatic test_wdata_stall();
    int k, bad, d0;
    k = 0;
    while (!cmd_ready && k < 200) begin @(posedge clk); #1; k++; end
    d0 = done_cnt;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 24'h123456; cmd_len_m1 = 8'd0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    k = 0;
    while (!wdata_ready && k < 200) begin @(posedge clk); #1; k++; end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (wb.stb_o || !wdata_ready) bad++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL stall_idle: got %0d bad cycles expected 0", bad); end
    wdata_valid = 1'b1; wdata = 8'h3C;
    @(posedge clk); #1;
    wdata_valid = 1'b0;
    k = 0;
    while (done_cnt == d0 && k < 500) begin @(posedge clk); #1; k++; end
    exp_mem[24'h123456] = 8'h3C;
    n_tests++;
    if (done_cnt == d0 || mem_rd(24'h123456) !== 8'h3C) begin
      n_fail++; $display("FAIL stall_resume: got %h (done %0d) expected 3c", mem_rd(24'h123456), done_cnt - d0);
    end
  endtask

  task automatic test_reset_in_poll();
    int k, l0, d0, r0; bit ok;
    logic [38:0] obs;
    stall_spi = 1'b1;
    k = 0;
    while (!cmd_ready && k < 200) begin @(posedge clk); #1; k++; end
    l0 = wb_log.size();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 24'h000010; cmd_len_m1 = 8'd0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    k = 0;
    while (wb_log.size() - l0 < 4 && k < 200) begin @(posedge clk); #1; k++; end
    repeat (10) @(posedge clk);
    d0 = done_cnt;
    #2 reset_n = 1'b0;
    #1;
    obs = {cmd_ready, wdata_ready, rdata_valid, done, err, wb.stb_o, wb.we_o,
           wb.adr_wr_o, wb.adr_rd_o, wb.dat_o, rdata};
    n_tests++;
    if (obs !== {7'b0, 8'h00, 8'h05, 8'h00, 8'h00}) begin
      n_fail++; $display("FAIL poll_async_reset: got %h expected %h", obs, {7'b0, 32'h00050000});
    end
    model_clr = 1'b1; stall_spi = 1'b0;
    @(posedge clk); #1;
    model_clr = 1'b0;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (cmd_ready !== 1'b1 || done_cnt != d0) begin
      n_fail++; $display("FAIL poll_reset_after: got ready %b done %0d expected 1/0", cmd_ready, done_cnt - d0);
    end
    r0 = rq.size();
    run_burst(1'b0, 24'h000010, 1, ok);
    n_tests++;
    if (!ok || rq.size() - r0 != 1 || rq[r0] !== exp_rd(24'h000010)) begin
      n_fail++; $display("FAIL poll_reset_read: got %0d bytes first %h expected %h", rq.size() - r0,
                         (rq.size() > r0) ? rq[r0] : 8'hxx, exp_rd(24'h000010));
    end
  endtask

  task automatic test_random();
    logic [23:0] a;
    int n, r0, bad, badm; bit ok;
    for (int it = 0; it < 6; it++) begin
      a = 24'($urandom);
      n = (it == 0) ? 256 : $urandom_range(40, 1);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
      run_burst(1'b1, a, n, ok);
      badm = 0;
      for (int i = 0; i < n; i++) if (mem_rd(exp_addr(a, i)) !== wq[i]) badm++;
      n_tests++;
      if (!ok || badm != 0) begin
        n_fail++; $display("FAIL rand_write%0d: got %0d wrong bytes (done %0b) addr %h len %0d expected 0", it, badm, ok, a, n);
      end
      r0 = rq.size();
      run_burst(1'b0, a, n, ok);
      bad = 0;
      if (rq.size() - r0 != n) bad = n;
      else for (int i = 0; i < n; i++) if (rq[r0 + i] !== exp_rd(exp_addr(a, i))) bad++;
      n_tests++;
      if (!ok || bad != 0) begin
        n_fail++; $display("FAIL rand_read%0d: got %0d wrong of %0d (count %0d) addr %h expected 0", it, bad, n, rq.size() - r0, a);
      end
    end
  endtask

`ifdef SRAM_BYTE_SEQUENCER_TIMEOUT_EN
  task automatic test_timeout();
    int l0, c0; bit ok;
    ack_all = 1'b1; stall_spi = 1'b1;
    l0 = wb_log.size(); c0 = csr_rst_cnt;
    wq = '{8'h77};
    run_burst(1'b1, 24'h000200, 1, ok);
    n_tests++;
    if (!ok || err !== 1'b1 || csr_rst_cnt != c0 + 1) begin
      n_fail++; $display("FAIL timeout_abort: got done %0b err %b csr_rst %0d expected 1/1/1", ok, err, csr_rst_cnt - c0);
    end
    n_tests++;
    if (wb_log.size() - l0 != 6 || wb_log[l0 + 5] !== 16'h0501 || log_cyc[l0 + 5] - log_cyc[l0 + 4] != 21) begin
      n_fail++; $display("FAIL timeout_timing: got %0d writes last %h gap %0d expected 6/0501/21", wb_log.size() - l0,
                         wb_log[wb_log.size() - 1], log_cyc[log_cyc.size() - 1] - log_cyc[log_cyc.size() - 2]);
    end
    stall_spi = 1'b0; ack_all = 1'b0;
    run_burst(1'b1, 24'h000200, 1, ok);
    n_tests++;
    if (!ok || err !== 1'b0 || mem_rd(24'h000200) !== 8'h77) begin
      n_fail++; $display("FAIL timeout_clear: got err %b mem %h expected 0/77", err, mem_rd(24'h000200));
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_one();
    test_read_four();
    test_wrap();
    test_wdata_stall();
    test_random();
    test_reset_in_poll();
`ifdef SRAM_BYTE_SEQUENCER_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
